// File: rtl/capture_sequencer.sv
// capture_sequencer: waits for a trigger, pulses the capture enable,
// waits for completion, and repeats with a holdoff gap between captures.
module capture_sequencer #(
    parameter int RW = 16,
    parameter int HW = 32,
    parameter int TW = 32
) (
    input  logic                pdh_clk,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [1:0]          trig_mode_i,
    input  logic                ext_trig_i,
    input  logic signed [15:0]  sample_i,
    input  logic signed [15:0]  thresh_i,
    input  logic [RW-1:0]       repeat_i,
    input  logic [HW-1:0]       holdoff_i,
    input  logic [TW-1:0]       timeout_i,
    output logic                cap_en_o,
    input  logic                cap_done_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_timeout_o,
    output logic [RW-1:0]       cap_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FIRE,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e             state_q;

    logic               start_q;
    logic               ext_trig_q;
    logic               cap_done_q;
    logic signed [15:0] sample_q;

    logic [1:0]         mode_q;
    logic signed [15:0] thresh_q;
    logic [RW-1:0]      rep_q;
    logic [HW-1:0]      hold_cfg_q;
    logic [TW-1:0]      tmo_cfg_q;

    logic [RW-1:0]      count_q;
    logic [RW-1:0]      count_d;
    logic [HW-1:0]      hold_q;
    logic [TW-1:0]      tmo_q;
    logic [TW-1:0]      tmo_d;
    logic               done_q;
    logic               err_q;

    logic               start_edge;
    logic               done_edge;
    logic               trig_hit;

    assign start_edge = start_i & ~start_q;
    assign done_edge  = cap_done_i & ~cap_done_q;
    assign count_d    = count_q + RW'(1);
    assign tmo_d      = tmo_q + TW'(1);

    // Previous-cycle copies of inputs used for edge and crossing detection.
    always_ff @(posedge pdh_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            start_q    <= 1'b0;
            ext_trig_q <= 1'b0;
            cap_done_q <= 1'b0;
            sample_q   <= '0;
        end else begin
            start_q    <= start_i;
            ext_trig_q <= ext_trig_i;
            cap_done_q <= cap_done_i;
            sample_q   <= sample_i;
        end
    end

    // Trigger condition for the latched mode; reserved mode acts as immediate.
    always_comb begin
        trig_hit = 1'b1;
        unique case (mode_q)
            2'd1:    trig_hit = ext_trig_i & ~ext_trig_q;
            2'd2:    trig_hit = (sample_q < thresh_q) && (sample_i >= thresh_q);
            default: trig_hit = 1'b1;
        endcase
    end

    // Sequencer state, latched configuration, counters and sticky status.
    always_ff @(posedge pdh_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            thresh_q   <= '0;
            rep_q      <= '0;
            hold_cfg_q <= '0;
            tmo_cfg_q  <= '0;
            count_q    <= '0;
            hold_q     <= '0;
            tmo_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else if (abort_i && state_q != S_IDLE) begin
            state_q <= S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_edge && !abort_i) begin
                        mode_q     <= trig_mode_i;
                        thresh_q   <= thresh_i;
                        rep_q      <= repeat_i;
                        hold_cfg_q <= holdoff_i;
                        tmo_cfg_q  <= timeout_i;
                        count_q    <= '0;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        state_q    <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (trig_hit) begin
                        state_q <= S_FIRE;
                    end
                end
                S_FIRE: begin
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    tmo_q <= tmo_d;
                    if (done_edge) begin
                        count_q <= count_d;
                        if (rep_q != '0 && count_d == rep_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else if (hold_cfg_q == '0) begin
                            state_q <= S_ARM;
                        end else begin
                            hold_q  <= hold_cfg_q;
                            state_q <= S_HOLD;
                        end
                    end else if (tmo_cfg_q != '0 && tmo_d == tmo_cfg_q) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (hold_q <= HW'(1)) begin
                        state_q <= S_ARM;
                    end else begin
                        hold_q <= hold_q - HW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cap_en_o      = (state_q == S_FIRE);
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign err_timeout_o = err_q;
    assign cap_count_o   = count_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: randomized and directed sequences checked against
// pulse times and final status predicted from the sequencing rules.
module tb_capture_sequencer;

    logic               clk;
    logic               rst_n;
    logic               start_i;
    logic               abort_i;
    logic [1:0]         trig_mode_i;
    logic               ext_trig_i;
    logic signed [15:0] sample_i;
    logic signed [15:0] thresh_i;
    logic [15:0]        repeat_i;
    logic [31:0]        holdoff_i;
    logic [31:0]        timeout_i;
    logic               cap_en_o;
    logic               cap_done_i;
    logic               busy_o;
    logic               done_o;
    logic               err_timeout_o;
    logic [15:0]        cap_count_o;

    int    errs   = 0;
    int    checks = 0;
    int    cyc    = 0;
    int    lat    = 0;
    int    due    = 0;
    bit    due_ok = 0;
    int    pulses[$];

    capture_sequencer #(.RW(16), .HW(32), .TW(32)) dut (
        .pdh_clk       (clk),
        .rst_ni        (rst_n),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .trig_mode_i   (trig_mode_i),
        .ext_trig_i    (ext_trig_i),
        .sample_i      (sample_i),
        .thresh_i      (thresh_i),
        .repeat_i      (repeat_i),
        .holdoff_i     (holdoff_i),
        .timeout_i     (timeout_i),
        .cap_en_o      (cap_en_o),
        .cap_done_i    (cap_done_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_timeout_o (err_timeout_o),
        .cap_count_o   (cap_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Cycle counter and capture-controller model: done pulses lat cycles
    // after each enable pulse (lat 0 = controller never completes).
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        cap_done_i = due_ok && (cyc == due);
    end

    // Pulse monitor: records enable cycles and the count seen at each one.
    always @(negedge clk) begin
        if (cap_en_o) begin
            chk("cnt_at_pulse", cap_count_o, pulses.size());
            pulses.push_back(cyc);
            if (lat != 0) begin
                due    = cyc + lat;
                due_ok = 1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(output int s);
        @(posedge clk);
        #1;
        start_i = 1'b1;
        s = cyc;
        step(1);
        start_i = 1'b0;
    endtask

    task automatic pulse_abort();
        abort_i = 1'b1;
        step(1);
        abort_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int end_cyc);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy_o) break;
        end
        chk("idle_wait", busy_o, 0);
        end_cyc = cyc;
    endtask

    task automatic config_in(input int m, input int r, input int h, input int t);
        trig_mode_i = 2'(m);
        repeat_i    = 16'(r);
        holdoff_i   = 32'(h);
        timeout_i   = 32'(t);
    endtask

    // Mode 0 run: pulse k at s+2+k*(L+H+2); idle one cycle after last done.
    task automatic run_m0(input int r, input int h, input int l, input int t);
        int s, e, per, last;
        config_in(0, r, h, t);
        lat = l;
        pulses.delete();
        do_start(s);
        chk("m0_busy_t1", busy_o, 1);
        wait_idle(r * (l + h + 2) + 20, e);
        per  = l + h + 2;
        last = s + 2 + (r - 1) * per;
        chk("m0_npulse", pulses.size(), r);
        if (pulses.size() == r) begin
            chk("m0_first", pulses[0], s + 2);
            chk("m0_last", pulses[r - 1], last);
        end
        chk("m0_end_cyc", e, last + l + 1);
        chk("m0_done", done_o, 1);
        chk("m0_err", err_timeout_o, 0);
        chk("m0_count", cap_count_o, r);
    endtask

    // Controller never completes: error one cycle after T WAIT cycles.
    task automatic run_tmo(input int t);
        int s, e;
        config_in(0, 1, 0, t);
        lat = 0;
        pulses.delete();
        do_start(s);
        goto(s + 2 + t);
        chk("to_busy_before", busy_o, 1);
        chk("to_err_before", err_timeout_o, 0);
        wait_idle(t + 20, e);
        chk("to_end_cyc", e, s + 2 + t + 1);
        chk("to_err", err_timeout_o, 1);
        chk("to_done", done_o, 0);
        chk("to_count", cap_count_o, 0);
        chk("to_npulse", pulses.size(), 1);
    endtask

    // Threshold ramp: one pulse the cycle after sample first reaches thresh.
    task automatic run_m2(input int th);
        int s;
        config_in(2, 2, 0, 0);
        thresh_i = 16'(th);
        sample_i = 16'(th - 5);
        lat = 3;
        pulses.delete();
        do_start(s);
        goto(s + 3);
        for (int k = 0; k <= 10; k++) begin
            sample_i = 16'(th - 5 + k);
            step(1);
        end
        step(25);
        chk("m2_npulse", pulses.size(), 1);
        if (pulses.size() == 1) chk("m2_pulse_cyc", pulses[0], s + 9);
        chk("m2_count", cap_count_o, 1);
        chk("m2_busy", busy_o, 1);
        pulse_abort();
        @(negedge clk);
        chk("m2_abort_busy", busy_o, 0);
        chk("m2_abort_done", done_o, 0);
    endtask

    // Continuous run aborted inside holdoff after five captures.
    task automatic run_abort();
        int s, p4;
        config_in(0, 0, 10, 0);
        lat = 4;
        pulses.delete();
        do_start(s);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pulses.size() >= 5) break;
        end
        chk("ab_npulse5", pulses.size(), 5);
        p4 = (pulses.size() >= 5) ? pulses[4] : 0;
        chk("ab_p4", p4, s + 2 + 4 * 16);
        goto(p4 + 7);
        chk("ab_busy_hold", busy_o, 1);
        chk("ab_count_hold", cap_count_o, 5);
        pulse_abort();
        @(negedge clk);
        chk("ab_busy", busy_o, 0);
        step(40);
        chk("ab_npulse_after", pulses.size(), 5);
        chk("ab_count", cap_count_o, 5);
        chk("ab_done", done_o, 0);
    endtask

    // External edge mode with ignored restarts and start+abort in IDLE.
    task automatic run_m1();
        int s, e;
        config_in(1, 2, 0, 0);
        ext_trig_i = 1'b0;
        lat = 3;
        pulses.delete();
        do_start(s);
        goto(s + 3);
        config_in(0, 7, 0, 0);
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        goto(s + 12);
        chk("m1_no_pulse", pulses.size(), 0);
        chk("m1_busy", busy_o, 1);
        ext_trig_i = 1'b1;
        e = cyc;
        step(4);
        ext_trig_i = 1'b0;
        goto(e + 12);
        chk("m1_npulse", pulses.size(), 1);
        if (pulses.size() == 1) chk("m1_pulse_cyc", pulses[0], e + 1);
        chk("m1_count", cap_count_o, 1);
        chk("m1_busy_arm", busy_o, 1);
        pulse_abort();
        start_i = 1'b1;
        abort_i = 1'b1;
        step(1);
        start_i = 1'b0;
        abort_i = 1'b0;
        step(5);
        chk("m1_sa_busy", busy_o, 0);
        chk("m1_sa_count", cap_count_o, 1);
        chk("m1_sa_npulse", pulses.size(), 1);
    endtask

    // Asynchronous reset in WAIT_DONE, then a fresh single capture.
    task automatic run_reset();
        int s;
        config_in(0, 0, 0, 0);
        lat = 3;
        pulses.delete();
        do_start(s);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pulses.size() >= 3) break;
        end
        chk("rs_npulse", pulses.size(), 3);
        @(negedge clk);
        chk("rs_count_pre", cap_count_o, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_cap_en", cap_en_o, 0);
        chk("rs_busy", busy_o, 0);
        chk("rs_done", done_o, 0);
        chk("rs_err", err_timeout_o, 0);
        chk("rs_count", cap_count_o, 0);
        due_ok = 0;
        step(2);
        rst_n = 1'b1;
        step(2);
        run_m0(1, 0, 5, 0);
    endtask

    initial begin
        int r, h, l, t, sel, th;
        rst_n       = 1'b0;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        ext_trig_i  = 1'b0;
        sample_i    = '0;
        thresh_i    = '0;
        cap_done_i  = 1'b0;
        config_in(0, 0, 0, 0);
        #2;
        chk("rst_cap_en", cap_en_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_timeout_o, 0);
        chk("rst_count", cap_count_o, 0);
        step(3);
        rst_n = 1'b1;
        step(2);

        run_m0(3, 10, 20, 0);
        for (int i = 0; i < 8; i++) begin
            r   = $urandom_range(4, 1);
            h   = $urandom_range(5, 0);
            l   = $urandom_range(8, 1);
            sel = $urandom_range(2, 0);
            t   = (sel == 0) ? 0 : (sel == 1) ? l : l + $urandom_range(10, 1);
            run_m0(r, h, l, t);
        end
        run_tmo(50);
        run_tmo($urandom_range(40, 3));
        run_m2(100);
        th = $urandom_range(600, 0);
        run_m2(th - 300);
        run_abort();
        run_m1();
        run_reset();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
